// File: rtl/pipelined_chunk_addsub_if.sv
// Operand/result handshake bundle for the chunked add/subtract unit.
// The master is the sequencer side; the slave is the arithmetic unit.
interface pipelined_chunk_addsub_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         sub;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] sum;
   logic         carry_flag;
   logic         overflow_flag;
   logic         zero_flag;
   logic         negative_flag;

   modport master (
      output in_valid, a, b, sub, cin, out_ready,
      input  in_ready, out_valid, sum, carry_flag, overflow_flag, zero_flag, negative_flag
   );

   modport slave (
      input  in_valid, a, b, sub, cin, out_ready,
      output in_ready, out_valid, sum, carry_flag, overflow_flag, zero_flag, negative_flag
   );
endinterface

// File: rtl/pipelined_chunk_addsub.sv
// Sequential N-bit add/subtract processed W bits per clock with the carry held
// in a register between chunks; sum and ALU flags are presented via valid/ready.
module pipelined_chunk_addsub #(
   parameter int N = 32,
   parameter int W = 8
) (
   input logic                     clk,
   input logic                     rst,
   pipelined_chunk_addsub_if.slave bus
);
   localparam int NCH = N / W;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

   generate
      if (N < 2 || W < 1 || W > N || (N % W) != 0) begin : g_bad_params
         $error("pipelined_chunk_addsub: need N >= 2, 1 <= W <= N and N %% W == 0");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         r_state;
   logic [N-1:0]   r_a;
   logic [N-1:0]   r_b;
   logic [N-1:0]   r_sum;
   logic           r_carry;
   logic           r_zacc;
   logic [IW-1:0]  r_idx;
   logic           r_in_ready;
   logic           r_out_valid;
   logic           r_c_flag;
   logic           r_v_flag;
   logic           r_z_flag;
   logic           r_n_flag;

   logic [W-1:0]   w_a_ch;
   logic [W-1:0]   w_b_ch;
   logic [W:0]     w_chunk;
   logic           w_last;
   logic           w_chunk_nz;

   // Subtraction is folded into addition: a - b - cin == a + ~b + !cin.
   assign w_a_ch     = r_a[int'(r_idx) * W +: W];
   assign w_b_ch     = r_b[int'(r_idx) * W +: W];
   assign w_chunk    = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{W{1'b0}}, r_carry};
   assign w_last     = (r_idx == LAST_IDX);
   assign w_chunk_nz = |w_chunk[W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
         r_zacc      <= 1'b0;
         r_idx       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_c_flag    <= 1'b0;
         r_v_flag    <= 1'b0;
         r_z_flag    <= 1'b0;
         r_n_flag    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_in_ready <= 1'b1;
               if (bus.in_valid && r_in_ready) begin
                  r_a        <= bus.a;
                  r_b        <= bus.sub ? ~bus.b : bus.b;
                  r_carry    <= bus.sub ? ~bus.cin : bus.cin;
                  r_zacc     <= 1'b0;
                  r_idx      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               r_sum[int'(r_idx) * W +: W] <= w_chunk[W-1:0];
               r_carry <= w_chunk[W];
               r_zacc  <= r_zacc | w_chunk_nz;
               r_idx   <= r_idx + IW'(1);
               // The last chunk holds bit N-1, so the flags are settled here.
               if (w_last) begin
                  r_c_flag    <= w_chunk[W];
                  r_v_flag    <= (w_a_ch[W-1] == w_b_ch[W-1]) && (w_chunk[W-1] != w_a_ch[W-1]);
                  r_z_flag    <= ~(r_zacc | w_chunk_nz);
                  r_n_flag    <= w_chunk[W-1];
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready      = r_in_ready;
   assign bus.out_valid     = r_out_valid;
   assign bus.sum           = r_sum;
   assign bus.carry_flag    = r_c_flag;
   assign bus.overflow_flag = r_v_flag;
   assign bus.zero_flag     = r_z_flag;
   assign bus.negative_flag = r_n_flag;
endmodule

// File: tb/tb_pipelined_chunk_addsub.sv
// Bench for pipelined_chunk_addsub: directed vectors on a 32/8 instance plus
// random sweeps on 32/32, 32/1 and 16/4, all checked against an arithmetic model.
module tb_pipelined_chunk_addsub;
   localparam int OPS = 1000;

   typedef struct packed {
      logic [31:0] s;
      logic        c;
      logic        v;
      logic        z;
      logic        neg;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   logic sweep_go;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   logic        t_in_valid, t_sub, t_cin, t_out_ready;
   logic [31:0] t_a, t_b;
   logic        t_in_ready, t_out_valid;
   logic [31:0] t_sum;
   logic [3:0]  t_flags;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int pn(input int i);
      case (i)
         3:       return 16;
         default: return 32;
      endcase
   endfunction

   function automatic int pw(input int i);
      case (i)
         1:       return 32;
         2:       return 1;
         3:       return 4;
         default: return 8;
      endcase
   endfunction

   // Golden result from plain integer arithmetic at width n.
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, input logic ci, input int n);
      longint m, ua, ub, sa, sb, c0, r, rs, lim;
      res_t o;
      m   = (longint'(1) << n) - 1;
      lim = longint'(1) << (n - 1);
      ua  = longint'(a) & m;
      ub  = longint'(b) & m;
      sa  = (ua >= lim) ? ua - (m + 1) : ua;
      sb  = (ub >= lim) ? ub - (m + 1) : ub;
      c0  = ci ? 1 : 0;
      if (!s) begin
         r   = ua + ub + c0;
         rs  = sa + sb + c0;
         o.c = ((r >> n) & 1) != 0;
      end else begin
         r   = ua - ub - c0;
         rs  = sa - sb - c0;
         o.c = (r >= 0);
      end
      o.s   = 32'(r & m);
      o.v   = (rs >= lim) || (rs < -lim);
      o.z   = ((r & m) == 0);
      o.neg = (((r & m) >> (n - 1)) & 1) != 0;
      return o;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_u
         localparam int NN    = pn(gi);
         localparam int WW    = pw(gi);
         localparam int NCH_L = NN / WW;

         logic          in_valid_l, in_ready_l, sub_l, cin_l;
         logic [NN-1:0] a_l, b_l, sum_l;
         logic          out_valid_l, out_ready_l;
         logic          c_l, v_l, z_l, n_l;
         logic          done_l;
         logic          ov_prev = 1'b0;
         res_t          q[$];
         int            accq[$];

         pipelined_chunk_addsub_if #(.N(NN)) ifc ();

         assign ifc.in_valid  = in_valid_l;
         assign ifc.a         = a_l;
         assign ifc.b         = b_l;
         assign ifc.sub       = sub_l;
         assign ifc.cin       = cin_l;
         assign ifc.out_ready = out_ready_l;
         assign in_ready_l    = ifc.in_ready;
         assign out_valid_l   = ifc.out_valid;
         assign sum_l         = ifc.sum;
         assign c_l           = ifc.carry_flag;
         assign v_l           = ifc.overflow_flag;
         assign z_l           = ifc.zero_flag;
         assign n_l           = ifc.negative_flag;

         pipelined_chunk_addsub #(.N(NN), .W(WW)) dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc.slave)
         );

         always @(negedge clk) begin
            if (rst) begin
               q.delete();
               accq.delete();
               ov_prev = 1'b0;
            end else begin
               if (in_valid_l && in_ready_l) begin
                  q.push_back(model(32'(a_l), 32'(b_l), sub_l, cin_l, NN));
                  accq.push_back(cyc + 1);
               end
               if (out_valid_l) begin
                  if (q.size() == 0) begin
                     chk($sformatf("u%0d.unexpected_out_valid", gi), 64'(out_valid_l), 64'd0);
                  end else begin
                     chk($sformatf("u%0d.sum", gi), 64'(sum_l), 64'(q[0].s));
                     chk($sformatf("u%0d.flags_cvzn", gi), 64'({c_l, v_l, z_l, n_l}),
                         64'({q[0].c, q[0].v, q[0].z, q[0].neg}));
                     chk($sformatf("u%0d.in_ready_in_done", gi), 64'(in_ready_l), 64'd0);
                     if (!ov_prev)
                        chk($sformatf("u%0d.latency", gi), 64'(cyc - accq[0]), 64'(NCH_L));
                     if (out_ready_l) begin
                        void'(q.pop_front());
                        void'(accq.pop_front());
                     end
                  end
               end
               ov_prev = out_valid_l;
            end
         end

         if (gi == 0) begin : g_dir
            assign in_valid_l  = t_in_valid;
            assign a_l         = t_a;
            assign b_l         = t_b;
            assign sub_l       = t_sub;
            assign cin_l       = t_cin;
            assign out_ready_l = t_out_ready;
            assign t_in_ready  = in_ready_l;
            assign t_out_valid = out_valid_l;
            assign t_sum       = sum_l;
            assign t_flags     = {c_l, v_l, z_l, n_l};
            assign done_l      = 1'b1;
         end else begin : g_rnd
            function automatic logic [NN-1:0] pick();
               case ($urandom_range(5))
                  0:       return '0;
                  1:       return '1;
                  2:       return {1'b1, {(NN-1){1'b0}}};
                  3:       return {1'b0, {(NN-1){1'b1}}};
                  default: return NN'($urandom);
               endcase
            endfunction

            initial begin
               out_ready_l = 1'b1;
               forever begin
                  @(posedge clk);
                  #1 out_ready_l = ($urandom_range(3) != 0);
               end
            end

            initial begin
               int n;
               in_valid_l = 1'b0;
               a_l = '0;
               b_l = '0;
               sub_l = 1'b0;
               cin_l = 1'b0;
               done_l = 1'b0;
               wait (sweep_go);
               @(posedge clk);
               #1;
               for (int k = 0; k < OPS; k++) begin
                  a_l = pick();
                  b_l = pick();
                  sub_l = 1'($urandom_range(1));
                  cin_l = 1'($urandom_range(1));
                  in_valid_l = 1'b1;
                  n = 0;
                  do begin
                     @(negedge clk);
                     n++;
                  end while (!in_ready_l && n < 200);
                  if (!in_ready_l) begin
                     chk($sformatf("u%0d.accept_timeout", gi), 64'(in_ready_l), 64'd1);
                     break;
                  end
                  @(posedge clk);
                  #1 in_valid_l = 1'b0;
                  a_l = ~a_l;
                  b_l = ~b_l;
               end
               n = 0;
               while (q.size() != 0 && n < 500) begin
                  @(negedge clk);
                  n++;
               end
               chk($sformatf("u%0d.drained", gi), 64'(q.size()), 64'd0);
               done_l = 1'b1;
            end
         end
      end
   endgenerate

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic ci, input logic [31:0] es, input logic [3:0] ef,
                         input string nm);
      int n;
      @(posedge clk);
      #1;
      t_a = a;
      t_b = b;
      t_sub = s;
      t_cin = ci;
      t_in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!t_in_ready && n < 20);
      if (!t_in_ready) begin
         chk({nm, ".accept"}, 64'(t_in_ready), 64'd1);
         t_in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      t_in_valid = 1'b0;
      t_a = ~a;
      t_b = ~b;
      t_sub = ~s;
      t_cin = ~ci;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!t_out_valid && n < 20);
      chk({nm, ".latency"}, 64'(n - 1), 64'd4);
      chk({nm, ".sum"}, 64'(t_sum), 64'(es));
      chk({nm, ".flags_cvzn"}, 64'(t_flags), 64'(ef));
   endtask

   initial begin
      logic seen;
      int   n;
      t_in_valid = 1'b0;
      t_a = '0;
      t_b = '0;
      t_sub = 1'b0;
      t_cin = 1'b0;
      t_out_ready = 1'b1;
      sweep_go = 1'b0;
      rst = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst.out_valid", 64'(t_out_valid), 64'd0);
      chk("rst.in_ready", 64'(t_in_ready), 64'd0);
      chk("rst.sum", 64'(t_sum), 64'd0);
      chk("rst.flags", 64'(t_flags), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rel.in_ready_before_edge", 64'(t_in_ready), 64'd0);
      @(negedge clk);
      chk("rel.in_ready_after_edge", 64'(t_in_ready), 64'd1);

      // Hand-worked results pin the model itself.
      chk("model.addwrap", 64'(model(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32)),
          64'({32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0}));
      chk("model.ovf", 64'(model(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32)),
          64'({32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1}));
      chk("model.borrow", 64'(model(32'd5, 32'd7, 1'b1, 1'b0, 32)),
          64'({32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1}));
      chk("model.sub_cin", 64'(model(32'd7, 32'd5, 1'b1, 1'b1, 32)),
          64'({32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0}));
      chk("model.n16", 64'(model(32'h0000_8000, 32'h0000_8000, 1'b0, 1'b0, 16)),
          64'({32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0}));

      run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 4'b1010, "addwrap");
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b0101, "ovf");
      run_op(32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 4'b0001, "borrow");
      run_op(32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0001, 4'b1000, "sub_cin");

      // Backpressure: result must hold while out_ready is low; new offers are dropped.
      @(posedge clk);
      #1 t_out_ready = 1'b0;
      run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0001, 4'b1100, "bp");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         t_in_valid = (i == 0);
         t_a = 32'd3;
         t_b = 32'd4;
         t_sub = 1'b0;
         t_cin = 1'b0;
         @(negedge clk);
         chk($sformatf("bp.hold%0d.out_valid", i), 64'(t_out_valid), 64'd1);
         chk($sformatf("bp.hold%0d.in_ready", i), 64'(t_in_ready), 64'd0);
         chk($sformatf("bp.hold%0d.sum", i), 64'(t_sum), 64'h0000_0001);
         chk($sformatf("bp.hold%0d.flags", i), 64'(t_flags), 64'b1100);
      end
      @(posedge clk);
      #1;
      t_in_valid = 1'b0;
      t_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp.release.out_valid", 64'(t_out_valid), 64'd0);
      chk("bp.release.in_ready", 64'(t_in_ready), 64'd1);
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen = seen | t_out_valid;
      end
      chk("bp.offer_ignored", 64'(seen), 64'd0);

      // Asynchronous reset during the second chunk.
      @(posedge clk);
      #1;
      t_a = 32'h0101_0101;
      t_b = 32'h0202_0202;
      t_sub = 1'b0;
      t_cin = 1'b0;
      t_in_valid = 1'b1;
      @(posedge clk);
      #1 t_in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst.out_valid", 64'(t_out_valid), 64'd0);
      chk("midrst.sum", 64'(t_sum), 64'd0);
      chk("midrst.flags", 64'(t_flags), 64'd0);
      chk("midrst.in_ready", 64'(t_in_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midrst.in_ready_after", 64'(t_in_ready), 64'd1);
      n = 0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | t_out_valid;
      end
      chk("midrst.no_partial_output", 64'(seen), 64'd0);
      run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 4'b0000, "after_rst");

      sweep_go = 1'b1;
      while (!(g_u[1].done_l && g_u[2].done_l && g_u[3].done_l) && n < 80000) begin
         @(negedge clk);
         n++;
      end
      chk("sweep.done", 64'({g_u[1].done_l, g_u[2].done_l, g_u[3].done_l}), 64'b111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
